// File: rtl/flash_bus_sequencer.sv
// ----------------------------------------------------------------------------
// flash_bus_sequencer
//
// Front end between a 6809 CPU bus and the SPI flash engine. The E clock is
// synchronised into the clk domain and each bus cycle is decoded against a
// 4 KB flash window. For every decoded cycle the CPU is stretched with MRDY,
// exactly one single-cycle request is issued to the engine, and read data is
// returned to the CPU bus until E falls.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined   : WAIT gives up after TIMEOUT_CYCLES clk cycles, returns 8'hFF
//               for reads and raises the sticky o_timeout flag.
//   Undefined : WAIT waits for i_done indefinitely and o_timeout is tied 0.
//
// Ports
//   clk            in   system clock, all state changes on its rising edge
//   reset          in   asynchronous active-low reset
//   i_E            in   6809 E clock, asynchronous to clk
//   i_ADDRESS_BUS  in   CPU address [15:0]
//   i_DataBus      in   CPU write data [7:0]
//   i_RW           in   1 = read, 0 = write
//   o_req          out  one-cycle request strobe to the flash engine
//   o_req_rw       out  latched i_RW
//   o_req_addr     out  latched A[11:0]
//   o_req_data     out  latched write data
//   i_done         in   engine completion pulse
//   i_rdata        in   engine read data, valid while i_done = 1
//   o_MemoryReady  out  MRDY to the CPU, 0 stretches E
//   o_DataOut      out  read data for the CPU data bus
//   o_DataOE       out  enables o_DataOut onto the bus
//   o_timeout      out  sticky timeout flag, cleared only by reset
// ----------------------------------------------------------------------------
module flash_bus_sequencer #(
    parameter logic [3:0]  FLASH_BASE     = 4'hE,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_E,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DataBus,
    input  logic        i_RW,
    output logic        o_req,
    output logic        o_req_rw,
    output logic [11:0] o_req_addr,
    output logic [7:0]  o_req_data,
    input  logic        i_done,
    input  logic [7:0]  i_rdata,
    output logic        o_MemoryReady,
    output logic [7:0]  o_DataOut,
    output logic        o_DataOE,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_HOLD
    } state_e;

    // The counter is loaded one below the cycle count because the load edge
    // itself is the first setup cycle.
    localparam logic [3:0] SETUP_LOAD = (SETUP_CYCLES > 0) ? 4'(SETUP_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;

    logic        e_meta_q, e_sync_q, e_prev_q;
    logic        e_rise, e_fall;
    logic        hit, accept, issue;
    logic        tmo_expire;

    logic [3:0]  setup_cnt_q;
    logic        rw_q;
    logic [11:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  dout_q;
    logic        req_q;

    // ------------------------------------------------------------------------
    // E synchroniser and edge detect
    // ------------------------------------------------------------------------
    // The chain resets to 1 so that an E already high when reset releases
    // (CPU stretched mid-cycle) is not mistaken for the start of a new cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_meta_q <= 1'b1;
            e_sync_q <= 1'b1;
            e_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what gives a real
            // three-stage pipeline instead of one collapsed stage.
            e_meta_q <= i_E;
            e_sync_q <= e_meta_q;
            e_prev_q <= e_sync_q;
        end
    end

    assign e_rise = e_sync_q & ~e_prev_q;
    assign e_fall = ~e_sync_q & e_prev_q;
    assign hit    = (i_ADDRESS_BUS[15:12] == FLASH_BASE);
    assign accept = (state_q == S_IDLE) && e_rise && hit;
    assign issue  = (state_q == S_SETUP) && (setup_cnt_q == 4'd0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // state_d, so no latch is inferred for unlisted conditions.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)              state_d = S_SETUP;
            S_SETUP: if (issue)               state_d = S_WAIT;
            // i_done is checked first so a completion coinciding with expiry
            // still counts as a good cycle.
            S_WAIT:  if (i_done || tmo_expire) state_d = S_HOLD;
            S_HOLD:  if (e_fall)              state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Both outputs decode straight from the state register, so an
    // asynchronous reset releases MRDY and the data bus without a clk edge.
    always_comb begin
        o_MemoryReady = 1'b1;
        o_DataOE      = 1'b0;
        unique case (state_q)
            S_SETUP, S_WAIT: o_MemoryReady = 1'b0;
            S_HOLD:          o_DataOE      = rw_q;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latches, setup counter and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every register here is a plain flop with a defined reset
            // value; there is no storage array, so nothing is left unreset.
            setup_cnt_q <= 4'd0;
            rw_q        <= 1'b1;
            addr_q      <= 12'd0;
            data_q      <= 8'd0;
            dout_q      <= 8'd0;
            req_q       <= 1'b0;
        end else begin
            req_q <= issue;

            if (accept) begin
                rw_q        <= i_RW;
                addr_q      <= i_ADDRESS_BUS[11:0];
                setup_cnt_q <= SETUP_LOAD;
            end else if ((state_q == S_SETUP) && (setup_cnt_q != 4'd0)) begin
                setup_cnt_q <= setup_cnt_q - 4'd1;
            end

            // Write data is captured as late as possible so it has settled.
            if (issue && !rw_q) begin
                data_q <= i_DataBus;
            end

            if ((state_q == S_WAIT) && rw_q) begin
                if (i_done) begin
                    dout_q <= i_rdata;
                end else if (tmo_expire) begin
                    dout_q <= 8'hFF;
                end
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Completion timeout
    // ------------------------------------------------------------------------
    localparam logic [15:0] TMO_LOAD = (TIMEOUT_CYCLES != 16'd0) ? (TIMEOUT_CYCLES - 16'd1) : 16'd0;

    logic [15:0] tmo_cnt_q;
    logic        timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (issue) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if ((state_q == S_WAIT) && (tmo_cnt_q != 16'd0)) begin
                tmo_cnt_q <= tmo_cnt_q - 16'd1;
            end

            if ((state_q == S_WAIT) && !i_done && tmo_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign tmo_expire = (state_q == S_WAIT) && (tmo_cnt_q == 16'd0);
    assign o_timeout  = timeout_q;
`else
    assign tmo_expire = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    assign o_req      = req_q;
    assign o_req_rw   = rw_q;
    assign o_req_addr = addr_q;
    assign o_req_data = data_q;
    assign o_DataOut  = dout_q;

endmodule

// File: tb/tb_flash_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_flash_bus_sequencer
//
// The driver plays both the CPU and the flash engine. For every bus cycle it
// also derives, from the bus-cycle timing rules (decode at edge 3, request at
// edge 3+SETUP, completion the edge after i_done or at expiry, release three
// edges after E falls), what each DUT output must be, and a single compare
// process checks the DUT against those expectations on every falling edge.
// ----------------------------------------------------------------------------
module tb_flash_bus_sequencer;

    localparam logic [3:0] BASE = 4'hE;
    localparam int         S    = 4;
    localparam int         T    = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_E;
    logic [15:0] i_ADDRESS_BUS;
    logic [7:0]  i_DataBus;
    logic        i_RW;
    logic        o_req;
    logic        o_req_rw;
    logic [11:0] o_req_addr;
    logic [7:0]  o_req_data;
    logic        i_done;
    logic [7:0]  i_rdata;
    logic        o_MemoryReady;
    logic [7:0]  o_DataOut;
    logic        o_DataOE;
    logic        o_timeout;

    flash_bus_sequencer #(
        .FLASH_BASE     (BASE),
        .SETUP_CYCLES   (S),
        .TIMEOUT_CYCLES (16'(T))
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_E           (i_E),
        .i_ADDRESS_BUS (i_ADDRESS_BUS),
        .i_DataBus     (i_DataBus),
        .i_RW          (i_RW),
        .o_req         (o_req),
        .o_req_rw      (o_req_rw),
        .o_req_addr    (o_req_addr),
        .o_req_data    (o_req_data),
        .i_done        (i_done),
        .i_rdata       (i_rdata),
        .o_MemoryReady (o_MemoryReady),
        .o_DataOut     (o_DataOut),
        .o_DataOE      (o_DataOE),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Expected outputs, maintained by the driver
    logic        exp_mrdy, exp_req, exp_rw, exp_oe, exp_to;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata, exp_dout;
    logic        cmp_en = 1'b0;

    // Event monitors for the literal timing checks
    int   req_seen = 0, req_expected = 0;
    int   req_cyc = 0, mrdy_fall_cyc = 0, mrdy_rise_cyc = 0, erise_cyc = 0;
    logic mrdy_prev = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reset_exp();
        exp_mrdy  = 1'b1;
        exp_req   = 1'b0;
        exp_rw    = 1'b1;
        exp_addr  = 12'd0;
        exp_wdata = 8'd0;
        exp_dout  = 8'd0;
        exp_oe    = 1'b0;
        exp_to    = 1'b0;
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Single compare process
    always @(negedge clk) begin
        if (o_req === 1'b1) begin
            req_seen++;
            req_cyc = cyc;
        end
        if (mrdy_prev && !o_MemoryReady) mrdy_fall_cyc = cyc;
        if (!mrdy_prev && o_MemoryReady) mrdy_rise_cyc = cyc;
        mrdy_prev = o_MemoryReady;
        if (cmp_en) begin
            check("mrdy",     o_MemoryReady, exp_mrdy);
            check("req",      o_req,         exp_req);
            check("req_rw",   o_req_rw,      exp_rw);
            check("req_addr", o_req_addr,    exp_addr);
            check("req_data", o_req_data,    exp_wdata);
            check("dout",     o_DataOut,     exp_dout);
            check("oe",       o_DataOE,      exp_oe);
            check("timeout",  o_timeout,     exp_to);
        end
    end

    // One CPU bus cycle plus the engine's response. lat = cycles after the
    // request edge before i_done is driven; hold = cycles E stays high after
    // completion; gap (>= 3) = cycles E stays low; rst_at >= 0 asserts reset
    // that many cycles into WAIT.
    task automatic do_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                            input logic [7:0] rdata, input int lat, input int hold,
                            input int gap, input int rst_at);
        logic hit;
        logic timed_out;
        int   comp;
        hit = (addr[15:12] == BASE);
        i_E = 1'b1;
        i_ADDRESS_BUS = addr;
        i_RW = rw;
        i_DataBus = 8'($urandom);
        erise_cyc = cyc;
        if (!hit) begin
            repeat (hold + 3) step();
            i_E = 1'b0;
            repeat (gap) step();
            return;
        end
        step();
        step();
        i_DataBus = wdata;
        step();
        exp_mrdy = 1'b0;
        exp_addr = addr[11:0];
        exp_rw   = rw;
        repeat (S) step();
        exp_req = 1'b1;
        req_expected++;
        if (!rw) exp_wdata = wdata;

        timed_out = 1'b0;
`ifdef BUS_TIMEOUT_EN
        if (lat + 1 > T) timed_out = 1'b1;
`endif
        comp = timed_out ? T : lat + 1;

        for (int j = 0; j < comp; j++) begin
            if (j == rst_at) begin
                #2;
                reset = 1'b0;
                set_reset_exp();
                #1;
                check("rst_async_mrdy", o_MemoryReady, 1'b1);
                check("rst_async_oe",   o_DataOE,      1'b0);
                step();
                step();
                reset = 1'b1;
                step();
                // A stale completion after reset must be ignored.
                i_done  = 1'b1;
                i_rdata = 8'hEE;
                step();
                i_done = 1'b0;
                repeat (2) step();
                i_E = 1'b0;
                repeat (gap) step();
                return;
            end
            if (!timed_out && j == lat) begin
                i_done  = 1'b1;
                i_rdata = rdata;
            end
            step();
            i_done  = 1'b0;
            i_rdata = 8'($urandom);
            exp_req = 1'b0;
            if (j + 1 == comp) begin
                exp_mrdy = 1'b1;
                exp_oe   = rw;
                if (rw) exp_dout = timed_out ? 8'hFF : rdata;
                if (timed_out) exp_to = 1'b1;
            end
        end

        for (int k = 0; k < hold; k++) begin
            if (k == 0 && timed_out) begin
                i_done  = 1'b1;
                i_rdata = 8'h11;
            end
            step();
            i_done = 1'b0;
        end
        i_E = 1'b0;
        for (int k = 1; k <= gap; k++) begin
            step();
            if (k == 3) exp_oe = 1'b0;
        end
    endtask

    initial begin
        int base_req;
        reset = 1'b0;
        i_E = 1'b0;
        i_ADDRESS_BUS = 16'h0000;
        i_DataBus = 8'h00;
        i_RW = 1'b1;
        i_done = 1'b0;
        i_rdata = 8'h00;
        set_reset_exp();
        cmp_en = 1'b1;
        repeat (3) step();

        // Reset values
        check("rst_mrdy",  o_MemoryReady, 1'b1);
        check("rst_req",   o_req,         1'b0);
        check("rst_rw",    o_req_rw,      1'b1);
        check("rst_addr",  o_req_addr,    12'h000);
        check("rst_dout",  o_DataOut,     8'h00);
        check("rst_oe",    o_DataOE,      1'b0);
        check("rst_to",    o_timeout,     1'b0);
        reset = 1'b1;
        repeat (4) step();

        // Read hit
        do_cycle(16'hE123, 1'b1, 8'h00, 8'h5A, 80, 6, 4, -1);
        check("rd_mrdy_fall_edge", mrdy_fall_cyc - erise_cyc, 3);
        check("rd_req_edge",       req_cyc - erise_cyc,       7);
        check("rd_mrdy_rise",      mrdy_rise_cyc - req_cyc,   81);
        check("rd_dout",           o_DataOut,                 8'h5A);
        check("rd_addr",           o_req_addr,                12'h123);
        check("rd_rw",             o_req_rw,                  1'b1);

        // Write hit
        do_cycle(16'hE0FF, 1'b0, 8'hC3, 8'h00, 10, 3, 4, -1);
        check("wr_data", o_req_data, 8'hC3);
        check("wr_rw",   o_req_rw,   1'b0);
        check("wr_addr", o_req_addr, 12'h0FF);
        check("wr_dout", o_DataOut,  8'h5A);

        // Miss
        base_req = req_seen;
        repeat (10) do_cycle(16'h8000, 1'b1, 8'h00, 8'h00, 0, 2, 3, -1);
        check("miss_req_pulses", req_seen - base_req, 0);

        // Reset while in WAIT, then a normal cycle
        do_cycle(16'hE456, 1'b1, 8'h00, 8'h77, 30, 3, 4, 10);
        do_cycle(16'hE789, 1'b1, 8'h00, 8'h42, 5, 3, 4, -1);
        check("post_rst_dout", o_DataOut,  8'h42);
        check("post_rst_addr", o_req_addr, 12'h789);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[15:12] = BASE;
            if ($urandom_range(0, 3) == 0) begin
                i_done  = 1'b1;
                i_rdata = 8'($urandom);
                step();
                i_done = 1'b0;
            end
            do_cycle(a, 1'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 40)), int'($urandom_range(1, 5)),
                     int'($urandom_range(3, 7)), -1);
        end

`ifdef BUS_TIMEOUT_EN
        // i_done on the expiry edge: completion wins
        do_cycle(16'hE222, 1'b1, 8'h00, 8'h3C, T - 1, 3, 4, -1);
        check("tie_timeout",   o_timeout,               1'b0);
        check("tie_dout",      o_DataOut,               8'h3C);
        check("tie_mrdy_rise", mrdy_rise_cyc - req_cyc, 100);

        // No i_done at all
        do_cycle(16'hE333, 1'b1, 8'h00, 8'h99, 500, 3, 4, -1);
        check("tmo_mrdy_rise", mrdy_rise_cyc - req_cyc, 100);
        check("tmo_dout",      o_DataOut,               8'hFF);
        check("tmo_flag",      o_timeout,               1'b1);

        // Flag is sticky through later good cycles
        do_cycle(16'hE444, 1'b0, 8'h5C, 8'h00, 3, 2, 4, -1);
        check("tmo_sticky", o_timeout,  1'b1);
        check("tmo_wdata",  o_req_data, 8'h5C);
`endif

        check("req_count", req_seen, req_expected);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_bus_sequencer.md
# flash_bus_sequencer

Upstream 6809 bus-cycle front end for the SPI flash engine. It synchronises the 6809 E clock into the `clk` domain and decodes the 4 KB flash window. For each decoded bus cycle it stretches the CPU with MRDY, issues exactly one single-cycle request to the flash engine, and returns read data to the CPU bus. It also holds MRDY low until the engine reports completion.

## Interface
Parameters:
- `FLASH_BASE`, `4'hE`: value of A[15:12] that selects the flash window.
- `SETUP_CYCLES`, `4`: `clk` cycles between cycle decode and request issue, so write data settles.
- `TIMEOUT_CYCLES`, `16'd4000`: maximum `clk` cycles spent waiting for `i_done`. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_E` in 1: 6809 E clock, asynchronous to `clk`.
- `i_ADDRESS_BUS` in 16: CPU address.
- `i_DataBus` in 8: CPU write data.
- `i_RW` in 1: 1 = read, 0 = write.
- `o_req` out 1: one-cycle request strobe to the flash engine.
- `o_req_rw` out 1: latched `i_RW`.
- `o_req_addr` out 12: latched A[11:0].
- `o_req_data` out 8: latched write data.
- `i_done` in 1: engine completion pulse, at least one `clk` wide.
- `i_rdata` in 8: engine read data, valid while `i_done`=1.
- `o_MemoryReady` out 1: MRDY to the CPU; 0 stretches E.
- `o_DataOut` out 8: read data for the CPU data bus.
- `o_DataOE` out 1: enables `o_DataOut` onto the bus.
- `o_timeout` out 1: sticky flag, set on a timeout, cleared only by reset.

## Operation
- **Reset values:** `o_req`=0, `o_req_rw`=1, `o_req_addr`=0, `o_req_data`=0, `o_MemoryReady`=1, `o_DataOut`=8'h00, `o_DataOE`=0, `o_timeout`=0, state=IDLE, all counters 0.
- **E synchronisation:** `i_E` passes through a 2-flop synchroniser plus an edge-detect register. E-rise and E-fall are single-cycle internal events.
- **Decode:** `hit` = (A[15:12]==FLASH_BASE), sampled on the E-rise cycle.
- **IDLE:**
  - E-rise with hit: latch address and RW, drive `o_MemoryReady`=0, load the setup counter, go to SETUP.
  - E-rise without hit: no action.
- **SETUP:** count down `SETUP_CYCLES`. On the terminal cycle, latch `i_DataBus` into `o_req_data` (writes only), pulse `o_req` for exactly one cycle, load the timeout counter, go to WAIT.
- **WAIT:**
  - On `i_done`: for a read, latch `i_rdata` into `o_DataOut`. Drive `o_MemoryReady`=1 and go to HOLD.
  - `i_done` in any state other than WAIT is ignored.
- **HOLD:**
  - `o_DataOE`=1 for reads, 0 for writes.
  - On E-fall: `o_DataOE`=0, go to IDLE.
  - A new cycle is never accepted before returning to IDLE.
- **Simultaneous events:**
  - `i_done` and timeout expiry in the same cycle: `i_done` wins and `o_timeout` is not set.
  - E-rise in the same cycle as a HOLD-to-IDLE transition is lost; this cannot happen at legal E rates.
- **Asynchronous reset mid-cycle** (any state): immediately `o_MemoryReady`=1 and `o_DataOE`=0. Any in-flight request is abandoned and no further `o_req` is issued.

## Timing
- Decode latency: E rises, then `o_MemoryReady` falls on the 3rd `clk` edge (2 synchroniser flops plus 1 register).
- `o_req` is asserted on edge 3+`SETUP_CYCLES` after E rises.
- `o_req_rw`, `o_req_addr` and `o_req_data` are stable from `o_req` assertion until the next accepted cycle.
- `o_MemoryReady` rises on the `clk` edge after `i_done` is sampled.
- `o_DataOut` is valid on that same edge and holds until the next read completes.
- Counter widths: setup counter 4 bits, timeout counter 16 bits, no wrap. Both counters count down to 0 and stop there.

## Configuration
- With `BUS_TIMEOUT_EN` defined:
  - In WAIT the timeout counter decrements each cycle.
  - When it reaches 0 without `i_done`: set `o_timeout`=1, `o_DataOut`=8'hFF (reads), `o_MemoryReady`=1, go to HOLD.
  - A late `i_done` is ignored.
- Without `BUS_TIMEOUT_EN`:
  - WAIT waits indefinitely for `i_done`.
  - The timeout counter is not instantiated and `o_timeout` is tied to 0.

## Test plan
- **Read hit:** A=16'hE123, RW=1, E rises; engine returns `i_done` with `i_rdata`=8'h5A after 80 cycles. Required: MRDY falls at edge 3; `o_req` is one pulse with `o_req_addr`=12'h123 and `o_req_rw`=1; MRDY rises the cycle after `i_done`; `o_DataOut`=8'h5A and `o_DataOE`=1 until E falls.
- **Write hit:** A=16'hE0FF, RW=0, data 8'hC3 settles 2 cycles after E rises. Required: `o_req_data`=8'hC3, `o_req_rw`=0, `o_DataOE` stays 0.
- **Miss:** A=16'h8000 for 10 E cycles. Required: zero `o_req` pulses and MRDY held at 1.
- **Timeout** (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, read, no `i_done`). Required: MRDY rises exactly 100 cycles after `o_req`; `o_DataOut`=8'hFF; `o_timeout`=1 and stays 1 through later good cycles. A test that `i_done` and expiry coinciding leaves `o_timeout`=0.
- **Reset in WAIT:** assert `reset`=0 asynchronously while in WAIT. Required: MRDY=1 and `o_DataOE`=0 without waiting for a `clk` edge; no `o_req` after release; the next hit cycle completes normally.
